// File: rtl/ysyx_22041207_mem_axi_bridge.sv
// Purpose: MEM-stage load/store responder; runs each accepted request as one single-beat AXI4-Lite transaction.
// Latency: accept at T, AXI address handshake T+1, response T+2, completion valid T+3 (zero-wait slave).
// Backpressure: requests accepted only in IDLE; completions held until MEM takes them; a watchdog bounds B/R waits.
//
// Ports: clk, rst_n (async, active low)
//   MEM write : w_valid_i/w_ready_o/w_addr_i/w_data_i/w_mask_i, completion w_valid_o/w_ready_i
//   MEM read  : rx_r_valid_i/rx_r_ready_o/rx_r_addr_i/rx_r_size_i, data rx_data_read_o/rx_data_valid/rx_data_ready
//   bus_err   : one-cycle pulse when a completion carries an error (slave error or watchdog expiry)
//   AXI4-Lite : AW, W, B, AR, R channels (single outstanding transaction)
module ysyx_22041207_mem_axi_bridge #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w_valid_i,
  output logic        w_ready_o,
  input  logic [63:0] w_addr_i,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_mask_i,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  input  logic        rx_r_valid_i,
  output logic        rx_r_ready_o,
  input  logic [63:0] rx_r_addr_i,
  input  logic [7:0]  rx_r_size_i,
  output logic [63:0] rx_data_read_o,
  output logic        rx_data_valid,
  input  logic        rx_data_ready,
  output logic        bus_err,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [63:0] araddr,
  output logic [2:0]  arsize,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp
);

  typedef enum logic [2:0] {
    IDLE, W_REQ, W_RESP, W_DONE, R_REQ, R_DATA, R_DONE
  } state_t;

  // Watchdog counts 0..TIMEOUT-1; the cycle it sits at TIMEOUT-1 is the last one allowed.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_next;
  logic [63:0]   addr_q;
  logic [63:0]   data_q;
  logic [7:0]    mask_q;
  logic [2:0]    size_q;
  logic          aw_done_q;
  logic          w_done_q;
  logic [TW-1:0] timer_q;
  logic          aw_hs;
  logic          w_hs;
  logic          wd_fire;

  function automatic logic [2:0] size_enc(input logic [7:0] s);
    case (s)
      8'd1:    return 3'd0;
      8'd2:    return 3'd1;
      8'd4:    return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

  assign w_ready_o     = (state == IDLE);
  assign rx_r_ready_o  = (state == IDLE);
  assign w_valid_o     = (state == W_DONE);
  assign rx_data_valid = (state == R_DONE);
  assign awvalid       = (state == W_REQ) && !aw_done_q;
  assign wvalid        = (state == W_REQ) && !w_done_q;
  assign bready        = (state == W_RESP);
  assign arvalid       = (state == R_REQ);
  assign rready        = (state == R_DATA);
  assign awaddr        = addr_q;
  assign wdata         = data_q;
  assign wstrb         = mask_q;
  assign araddr        = {addr_q[63:3], 3'b000};
  assign arsize        = size_q;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign wd_fire = (TIMEOUT != 0) && (timer_q == WD_LAST) &&
                   ((state == W_RESP) || (state == R_DATA));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // Write wins a tie; the read stays pending on the MEM side.
        if (w_valid_i)         state_next = W_REQ;
        else if (rx_r_valid_i) state_next = R_REQ;
      end
      W_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_next = W_RESP;
      W_RESP: if (bvalid || wd_fire) state_next = W_DONE;
      W_DONE: if (w_ready_i) state_next = IDLE;
      R_REQ:  if (arready) state_next = R_DATA;
      R_DATA: if (rvalid || wd_fire) state_next = R_DONE;
      R_DONE: if (rx_data_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      data_q         <= '0;
      mask_q         <= '0;
      size_q         <= '0;
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      timer_q        <= '0;
      rx_data_read_o <= '0;
      bus_err        <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (w_valid_i) begin
            addr_q <= w_addr_i;
            data_q <= w_data_i;
            mask_q <= w_mask_i;
          end else if (rx_r_valid_i) begin
            addr_q <= rx_r_addr_i;
            size_q <= size_enc(rx_r_size_i);
          end
        end
        W_REQ: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
        end
        W_RESP: begin
          // A real response beats an expiring watchdog in the same cycle.
          if (bvalid)       bus_err <= |bresp;
          else if (wd_fire) bus_err <= 1'b1;
        end
        R_DATA: begin
          if (rvalid) begin
            rx_data_read_o <= rdata >> {addr_q[2:0], 3'b000};
            bus_err        <= |rresp;
          end else if (wd_fire) begin
            rx_data_read_o <= '0;
            bus_err        <= 1'b1;
          end
        end
        default: ;
      endcase

      if (state_next != state) begin
        timer_q <= '0;
      end else if ((state == W_RESP) || (state == R_DATA)) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041207_mem_axi_bridge.sv
// Scoreboard bench for the MEM-to-AXI4-Lite bridge: a randomized driver pushes
// expected AXI beats and completions into queues; an AXI slave model and a
// completion monitor pop and compare them independently.
module tb_ysyx_22041207_mem_axi_bridge;

  localparam int TO = 8;

  logic        clk, rst_n;
  logic        w_valid_i, w_ready_o, w_valid_o, w_ready_i;
  logic [63:0] w_addr_i, w_data_i;
  logic [7:0]  w_mask_i;
  logic        rx_r_valid_i, rx_r_ready_o;
  logic [63:0] rx_r_addr_i;
  logic [7:0]  rx_r_size_i;
  logic [63:0] rx_data_read_o;
  logic        rx_data_valid, rx_data_ready, bus_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic [2:0]  arsize;
  logic [1:0]  bresp, rresp;

  ysyx_22041207_mem_axi_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_addr_i(w_addr_i),
    .w_data_i(w_data_i), .w_mask_i(w_mask_i), .w_valid_o(w_valid_o),
    .w_ready_i(w_ready_i), .rx_r_valid_i(rx_r_valid_i), .rx_r_ready_o(rx_r_ready_o),
    .rx_r_addr_i(rx_r_addr_i), .rx_r_size_i(rx_r_size_i),
    .rx_data_read_o(rx_data_read_o), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .bus_err(bus_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    bit          hang;
    int          aw_d, w_d, ar_d, rsp_d;
    logic [1:0]  rsp;
    logic [63:0] rdata;
  } cfg_t;
  typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] strb; } wexp_t;
  typedef struct { logic [63:0] addr; logic [2:0] size; } rexp_t;
  typedef struct { logic [63:0] data; bit err; } cexp_t;

  cfg_t  cfg_q[$];
  wexp_t aw_q[$];
  rexp_t ar_q[$];
  bit    wc_q[$];
  cexp_t rc_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event, expected one within the bound", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] exp_size(input int s);
    for (int k = 0; k < 4; k++) if (s == (1 << k)) return 3'(k);
    return 3'd3;
  endfunction

  // Byte at the requested address lands in byte 0; bytes past the word end are zero.
  function automatic logic [63:0] exp_rd(input logic [63:0] d, input logic [2:0] off);
    logic [63:0] r;
    int o;
    r = '0;
    o = int'(off);
    for (int i = 0; i < 8; i++) if (i + o < 8) r[i*8 +: 8] = d[(i+o)*8 +: 8];
    return r;
  endfunction

  function automatic cfg_t zero_cfg(input bit wr);
    cfg_t c;
    c.is_wr = wr; c.hang = 1'b0;
    c.aw_d = 0; c.w_d = 0; c.ar_d = 0; c.rsp_d = 0;
    c.rsp = 2'd0; c.rdata = {$urandom, $urandom};
    return c;
  endfunction

  function automatic cfg_t rnd_cfg(input bit wr);
    cfg_t c;
    c = zero_cfg(wr);
    c.aw_d  = $urandom_range(0, 3);
    c.w_d   = $urandom_range(0, 3);
    c.ar_d  = $urandom_range(0, 3);
    c.rsp_d = $urandom_range(0, 4);
    c.hang  = ($urandom_range(0, 9) == 0);
    c.rsp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    return c;
  endfunction

  task automatic push_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m, input cfg_t c);
    wexp_t e;
    e.addr = a; e.data = d; e.strb = m;
    aw_q.push_back(e);
    cfg_q.push_back(c);
    wc_q.push_back(c.hang || (c.rsp != 2'd0));
  endtask

  task automatic push_rd(input logic [63:0] a, input int sz, input cfg_t c);
    rexp_t e;
    cexp_t ce;
    e.addr = a & ~64'h7;
    e.size = exp_size(sz);
    ar_q.push_back(e);
    cfg_q.push_back(c);
    ce.data = c.hang ? 64'd0 : exp_rd(c.rdata, a[2:0]);
    ce.err  = c.hang || (c.rsp != 2'd0);
    rc_q.push_back(ce);
  endtask

  // ---------------- driver ----------------
  task automatic wait_rdy(input bit rd, input string name);
    int n;
    n = 0;
    while ((rd ? rx_r_ready_o : w_ready_o) !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        fail(name);
        return;
      end
    end
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m,
                          input cfg_t c, input bit lat);
    push_wr(a, d, m, c);
    @(negedge clk);
    w_addr_i = a; w_data_i = d; w_mask_i = m; w_valid_i = 1'b1;
    wait_rdy(1'b0, "write_accept");
    @(negedge clk);
    w_valid_i = 1'b0;
    if (lat) begin
      chk("lat_awvalid_t0", awvalid, 1'b1);
      @(negedge clk);
      chk("lat_wvalid_o_t2", w_valid_o, 1'b0);
      @(negedge clk);
      chk("lat_wvalid_o_t3", w_valid_o, 1'b1);
    end
  endtask

  task automatic do_read(input logic [63:0] a, input int sz, input cfg_t c);
    push_rd(a, sz, c);
    @(negedge clk);
    rx_r_addr_i = a; rx_r_size_i = 8'(sz); rx_r_valid_i = 1'b1;
    wait_rdy(1'b1, "read_accept");
    @(negedge clk);
    rx_r_valid_i = 1'b0;
  endtask

  task automatic do_both(input logic [63:0] wa, input logic [63:0] wd, input logic [7:0] wm,
                         input cfg_t wc, input logic [63:0] ra, input int rs, input cfg_t rc);
    push_wr(wa, wd, wm, wc);
    push_rd(ra, rs, rc);
    @(negedge clk);
    w_addr_i = wa; w_data_i = wd; w_mask_i = wm; w_valid_i = 1'b1;
    rx_r_addr_i = ra; rx_r_size_i = 8'(rs); rx_r_valid_i = 1'b1;
    wait_rdy(1'b0, "both_write_accept");
    @(negedge clk);
    w_valid_i = 1'b0;
    wait_rdy(1'b1, "both_read_accept");
    @(negedge clk);
    rx_r_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wc_q.size() != 0 || rc_q.size() != 0 || cfg_q.size() != 0 || w_ready_o !== 1'b1)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail("drain");
  endtask

  // ---------------- AXI slave model ----------------
  task automatic slave_wr(input cfg_t c);
    wexp_t e;
    int awc, wc, awn, wn, rc, hn, g;
    bit awd, wd;
    e = '{default: 0};
    if (aw_q.size() != 0) e = aw_q.pop_front();
    else fail("aw_expect_empty");
    awc = 0; wc = 0; awn = 0; wn = 0; rc = 0; hn = 0; g = 0; awd = 0; wd = 0;
    while (!(awd && wd)) begin
      if (!rst_n) begin awready = 0; wready = 0; return; end
      if (awvalid) awn++;
      if (wvalid) wn++;
      if (!awd) begin
        awready = (awc >= c.aw_d); awc++;
        if (awvalid && awready) begin awd = 1; chk("awaddr", awaddr, e.addr); end
      end else awready = 1'b0;
      if (!wd) begin
        wready = (wc >= c.w_d); wc++;
        if (wvalid && wready) begin
          wd = 1;
          chk("wdata", wdata, e.data);
          chk("wstrb", wstrb, e.strb);
        end
      end else wready = 1'b0;
      @(negedge clk);
      g++;
      if (g > 100) begin fail("aw_w_handshake"); awready = 0; wready = 0; return; end
    end
    awready = 1'b0; wready = 1'b0;
    while (1) begin
      if (!rst_n) begin bvalid = 0; return; end
      if (awvalid) awn++;
      if (wvalid) wn++;
      if (!bready) break;
      hn++;
      if (!c.hang && rc >= c.rsp_d) begin bvalid = 1'b1; bresp = c.rsp; end
      rc++;
      @(negedge clk);
      g++;
      if (g > 100) begin fail("b_phase"); bvalid = 0; return; end
    end
    bvalid = 1'b0;
    bresp  = 2'($urandom);
    chk("awvalid_cycles", awn, c.aw_d + 1);
    chk("wvalid_cycles", wn, c.w_d + 1);
    chk("bready_cycles", hn, c.hang ? TO : c.rsp_d + 1);
  endtask

  task automatic slave_rd(input cfg_t c);
    rexp_t e;
    int arc, arn, rc, hn, g;
    bit done;
    e = '{default: 0};
    if (ar_q.size() != 0) e = ar_q.pop_front();
    else fail("ar_expect_empty");
    arc = 0; arn = 0; rc = 0; hn = 0; g = 0; done = 0;
    while (!done) begin
      if (!rst_n) begin arready = 0; return; end
      if (arvalid) arn++;
      arready = (arc >= c.ar_d); arc++;
      if (arvalid && arready) begin
        done = 1;
        chk("araddr", araddr, e.addr);
        chk("arsize", arsize, e.size);
      end
      @(negedge clk);
      g++;
      if (g > 100) begin fail("ar_handshake"); arready = 0; return; end
    end
    arready = 1'b0;
    if (arvalid) arn++;
    chk("arvalid_cycles", arn, c.ar_d + 1);
    while (1) begin
      if (!rst_n) begin rvalid = 0; return; end
      if (!rready) break;
      hn++;
      if (!c.hang && rc >= c.rsp_d) begin rvalid = 1'b1; rdata = c.rdata; rresp = c.rsp; end
      rc++;
      @(negedge clk);
      g++;
      if (g > 100) begin fail("r_phase"); rvalid = 0; return; end
    end
    rvalid = 1'b0;
    rdata  = {$urandom, $urandom};
    rresp  = 2'($urandom);
    chk("rready_cycles", hn, c.hang ? TO : c.rsp_d + 1);
  endtask

  initial begin : slave
    cfg_t c;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (rst_n && (awvalid || wvalid || arvalid)) begin
        if (cfg_q.size() == 0) begin
          fail("axi_txn_unexpected");
          repeat (4) @(negedge clk);
        end else begin
          c = cfg_q.pop_front();
          chk("txn_kind_is_write", (awvalid || wvalid), c.is_wr);
          if (awvalid || wvalid) slave_wr(c);
          else slave_rd(c);
        end
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin : monitor
    bit    w_seen, r_seen, r_have, first_w, first_r, we;
    cexp_t rcur;
    w_seen = 0; r_seen = 0; r_have = 0;
    rcur = '{default: 0};
    w_ready_i = 0; rx_data_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        w_seen = 0; r_seen = 0; r_have = 0;
        continue;
      end
      first_w = w_valid_o && !w_seen;
      first_r = rx_data_valid && !r_seen;
      if (bus_err && !first_w && !first_r) begin
        checks++; errors++;
        $display("FAIL bus_err_stray: got 1 expected 0 outside a completion entry cycle");
      end
      if (first_w) begin
        if (wc_q.size() == 0) fail("write_comp_expected");
        else begin
          we = wc_q.pop_front();
          chk("write_bus_err", bus_err, we);
        end
      end
      w_seen = w_valid_o;
      if (first_r) begin
        if (rc_q.size() == 0) begin fail("read_comp_expected"); r_have = 0; end
        else begin
          rcur = rc_q.pop_front();
          r_have = 1;
          chk("read_bus_err", bus_err, rcur.err);
        end
      end
      if (rx_data_valid && r_have) chk("read_data", rx_data_read_o, rcur.data);
      r_seen = rx_data_valid;
      if (!rx_data_valid) r_have = 0;
      w_ready_i     = ($urandom_range(0, 3) != 0);
      rx_data_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    cfg_t c, c2;
    int   n, sz;
    int   sizes[6];
    logic [63:0] a;
    sizes = '{1, 2, 4, 8, 3, 0};
    rst_n = 1'b0;
    w_valid_i = 0; w_addr_i = 0; w_data_i = 0; w_mask_i = 0;
    rx_r_valid_i = 0; rx_r_addr_i = 0; rx_r_size_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_valids", {w_valid_o, rx_data_valid, bus_err, awvalid, wvalid, bready, arvalid, rready}, 8'd0);
    chk("rst_rdata", rx_data_read_o, 64'd0);
    chk("rst_awaddr", awaddr, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {w_ready_o, rx_r_ready_o}, 2'b11);

    c = zero_cfg(1);
    do_write(64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, c, 1'b1);

    c = zero_cfg(1); c.aw_d = 3;
    do_write(64'h8000_0100, {$urandom, $urandom}, 8'h0F, c, 1'b0);

    c = zero_cfg(0); c.rdata = 64'hAABB_CCDD_EEFF_0011;
    do_read(64'h8000_0005, 2, c);

    c = rnd_cfg(1); c.hang = 0; c2 = rnd_cfg(0); c2.hang = 0;
    do_both(64'h8000_0200, {$urandom, $urandom}, 8'hF0, c, 64'h8000_0203, 4, c2);

    c = zero_cfg(0); c.hang = 1;
    do_read(64'h8000_0300, 8, c);
    c = zero_cfg(1); c.rsp = 2'd2;
    do_write(64'h8000_0308, {$urandom, $urandom}, 8'h3C, c, 1'b0);

    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 2);
      a = {$urandom, $urandom};
      sz = sizes[$urandom_range(0, 5)];
      if (n == 0) do_write(a & ~64'h7, {$urandom, $urandom}, 8'($urandom), rnd_cfg(1), 1'b0);
      else if (n == 1) do_read(a, sz, rnd_cfg(0));
      else do_both({$urandom, $urandom} & ~64'h7, {$urandom, $urandom}, 8'($urandom), rnd_cfg(1),
                   a, sz, rnd_cfg(0));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // Asynchronous reset while waiting in W_RESP.
    c = zero_cfg(0); c.rdata = 64'hFFEE_DDCC_BBAA_9988;
    do_read(64'h8000_0400, 8, c);
    drain();
    c = zero_cfg(1); c.hang = 1;
    do_write(64'h8000_0500, {$urandom, $urandom}, 8'hFF, c, 1'b0);
    n = 0;
    while (bready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("reach_w_resp", bready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valids", {w_valid_o, rx_data_valid, bus_err, awvalid, wvalid, bready, arvalid, rready}, 8'd0);
    chk("arst_rdata", rx_data_read_o, 64'd0);
    chk("arst_idle", w_ready_o, 1'b1);
    aw_q.delete(); ar_q.delete(); cfg_q.delete(); wc_q.delete(); rc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c = zero_cfg(1);
    do_write(64'h8000_0600, 64'h0123_4567_89AB_CDEF, 8'hFF, c, 1'b1);
    drain();

    chk("left_write_comps", wc_q.size(), 0);
    chk("left_read_comps", rc_q.size(), 0);
    chk("end_idle", {w_ready_o, rx_r_ready_o}, 2'b11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
